data_stack: RTL and testbench

DATA_STACK -- requirements
Module: data_stack

---
 rtl/data_stack_pkg.sv | 55 +++++
 rtl/stack_mem.sv | 27 ++
 rtl/data_stack.sv | 163 ++++++++++++++++
 tb/tb_data_stack.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/data_stack_pkg.sv
// Shared opcode definitions and command decode for the data stack and the instruction decoder.
// decode_op() states, for each opcode, how it moves the stack and how deep the stack must be.
package data_stack_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_DROP = 3'b010,
        OP_BIN  = 3'b011,
        OP_UNA  = 3'b100,
        OP_SWAP = 3'b101,
        OP_DUP  = 3'b110,
        OP_OVER = 3'b111
    } op_e;

    typedef struct packed {
        logic       grow;       // adds one element
        logic       shrink;     // removes one element
        logic [1:0] min_depth;  // elements that must already be present
    } op_dec_t;

    function automatic op_dec_t decode_op(input op_e op);
        op_dec_t d;
        d = '0;
        case (op)
            OP_PUSH: begin
                d.grow      = 1'b1;
                d.min_depth = 2'd0;
            end
            OP_DROP: begin
                d.shrink    = 1'b1;
                d.min_depth = 2'd1;
            end
            OP_BIN: begin
                d.shrink    = 1'b1;
                d.min_depth = 2'd2;
            end
            OP_UNA:  d.min_depth = 2'd1;
            OP_SWAP: d.min_depth = 2'd2;
            OP_DUP: begin
                d.grow      = 1'b1;
                d.min_depth = 2'd1;
            end
            OP_OVER: begin
                d.grow      = 1'b1;
                d.min_depth = 2'd2;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Register array holding the stack cells below Y.
// The write lands on the rising clock edge; the read port is purely combinational.
module stack_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 16,
    localparam int ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    // No reset: nothing below Y is read until it has been written.
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_stack.sv
// Stack with T and Y in registers and deeper cells in stack_mem.
// Every accepted command completes in one clock. Illegal commands change nothing and set a sticky flag.
module data_stack
    import data_stack_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [OP_W-1:0]                  op,
    input  logic                             op_valid,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic [DATA_WIDTH-1:0]            result,
    input  logic                             err_clr,
    output logic [DATA_WIDTH-1:0]            T,
    output logic [DATA_WIDTH-1:0]            Y,
    output logic [$clog2(MEM_DEPTH+3)-1:0]   depth,
    output logic                             empty,
    output logic                             full,
    output logic                             ovf,
    output logic                             unf
);

    localparam int CAP     = MEM_DEPTH + 2;
    localparam int DEPTH_W = $clog2(CAP + 1);
    localparam int PTR_W   = $clog2(MEM_DEPTH + 1);
    localparam int ADDR_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_t;
    logic [DATA_WIDTH-1:0] r_y;
    logic [DEPTH_W-1:0]    r_depth;
    logic [PTR_W-1:0]      r_ptr;
    logic                  r_ovf;
    logic                  r_unf;

    op_e                   w_op;
    op_dec_t               w_dec;
    logic                  w_cmd;
    logic                  w_ovf_evt;
    logic                  w_unf_evt;
    logic                  w_exec;
    logic                  w_ge2;
    logic                  w_has_mem;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic [DATA_WIDTH-1:0] w_mem_top;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_t_nxt;
    logic [DATA_WIDTH-1:0] w_y_nxt;
    logic [DEPTH_W-1:0]    w_depth_nxt;
    logic [PTR_W-1:0]      w_ptr_nxt;

    // op_valid qualifies op for the single edge on which it is high. There is no ready:
    // every command is taken that edge, and one that would break the stack only raises ovf/unf.
    assign w_op  = op_e'(op);
    assign w_dec = decode_op(w_op);
    assign w_cmd = op_valid && (w_op != OP_NOP);

    assign w_ovf_evt = w_cmd && w_dec.grow && (r_depth == DEPTH_W'(CAP));
    assign w_unf_evt = w_cmd && (r_depth < DEPTH_W'(w_dec.min_depth));
    assign w_exec    = w_cmd && !w_ovf_evt && !w_unf_evt;

    // r_ptr counts the cells spilled to memory (depth-2); memory top sits at r_ptr-1.
    assign w_ge2     = (r_depth >= DEPTH_W'(2));
    assign w_has_mem = (r_ptr != '0);
    assign w_mem_top = w_has_mem ? w_mem_rdata : '0;

    always_comb begin
        w_t_nxt     = r_t;
        w_y_nxt     = r_y;
        w_depth_nxt = r_depth;
        w_ptr_nxt   = r_ptr;
        w_mem_we    = 1'b0;
        if (w_exec) begin
            case (w_op)
                OP_PUSH: begin
                    w_t_nxt = din;
                    w_y_nxt = r_t;
                end
                OP_DROP: begin
                    w_t_nxt = r_y;
                    w_y_nxt = w_mem_top;
                end
                OP_BIN: begin
                    w_t_nxt = result;
                    w_y_nxt = w_mem_top;
                end
                OP_UNA: w_t_nxt = result;
                OP_SWAP, OP_OVER: begin
                    w_t_nxt = r_y;
                    w_y_nxt = r_t;
                end
                OP_DUP: w_y_nxt = r_t;
                default: ;
            endcase
            if (w_dec.grow) begin
                w_depth_nxt = r_depth + DEPTH_W'(1);
                if (w_ge2) begin
                    w_mem_we  = 1'b1;
                    w_ptr_nxt = r_ptr + PTR_W'(1);
                end
            end
            if (w_dec.shrink) begin
                w_depth_nxt = r_depth - DEPTH_W'(1);
                if (w_has_mem) begin
                    w_ptr_nxt = r_ptr - PTR_W'(1);
                end
            end
        end
    end

    stack_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_stack_mem (
        .i_clk  (clk),
        .i_we   (w_mem_we),
        .i_waddr(ADDR_W'(r_ptr)),
        .i_wdata(r_y),
        .i_raddr(ADDR_W'(r_ptr - PTR_W'(1))),
        .o_rdata(w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t <= '0;
            r_y <= '0;
        end else begin
            r_t <= w_t_nxt;
            r_y <= w_y_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= '0;
            r_ptr   <= '0;
        end else begin
            r_depth <= w_depth_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // A new error on the same edge as err_clr keeps its flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_evt || (r_ovf && !err_clr);
            r_unf <= w_unf_evt || (r_unf && !err_clr);
        end
    end

    assign T     = r_t;
    assign Y     = r_y;
    assign depth = r_depth;
    assign empty = (r_depth == '0);
    assign full  = (r_depth == DEPTH_W'(CAP));
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack (DATA_WIDTH=16, MEM_DEPTH=16, CAP=18).
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_data_stack;
    import data_stack_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  op;
    logic        op_valid;
    logic [15:0] din;
    logic [15:0] result;
    logic        err_clr;
    logic [15:0] T;
    logic [15:0] Y;
    logic [4:0]  depth;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [15:0] exp_q[$];

    data_stack #(.DATA_WIDTH(16), .MEM_DEPTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (op),
        .op_valid(op_valid),
        .din     (din),
        .result  (result),
        .err_clr (err_clr),
        .T       (T),
        .Y       (Y),
        .depth   (depth),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        op_valid = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // driver: one command for exactly one rising edge
    task automatic drive(input logic [2:0] op_i, input logic [15:0] din_i,
                         input logic [15:0] res_i, input logic valid_i, input logic clr_i);
        @(negedge clk);
        op       = op_i;
        din      = din_i;
        result   = res_i;
        op_valid = valid_i;
        err_clr  = clr_i;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic push(input logic [15:0] v);
        drive(OP_PUSH, v, 16'd0, 1'b1, 1'b0);
    endtask

    task automatic cmd(input logic [2:0] op_i, input logic [15:0] res_i);
        drive(op_i, 16'd0, res_i, 1'b1, 1'b0);
    endtask

    task automatic check_stack(input string tag, input logic [15:0] t_e,
                               input logic [15:0] y_e, input logic [4:0] d_e);
        check_eq({tag, ".T"}, T, t_e);
        check_eq({tag, ".Y"}, Y, y_e);
        check_eq({tag, ".depth"}, depth, d_e);
    endtask

    initial begin
        op = 3'd0; din = '0; result = '0;
        apply_reset();
        check_stack("reset", 16'd0, 16'd0, 5'd0);
        check_eq("reset.empty", empty, 1'b1);
        check_eq("reset.full", full, 1'b0);
        check_eq("reset.ovf", ovf, 1'b0);
        check_eq("reset.unf", unf, 1'b0);

        // 5 + 7 computed externally as 12
        push(16'd5);
        push(16'd7);
        check_stack("push57", 16'd7, 16'd5, 5'd2);
        cmd(OP_BIN, 16'd12);
        check_stack("bin12", 16'd12, 16'd0, 5'd1);
        check_eq("bin12.ovf", ovf, 1'b0);
        check_eq("bin12.unf", unf, 1'b0);

        // SWAP / OVER / DROP / UNA / DUP, including a spill to memory and back
        apply_reset();
        push(16'd3);
        push(16'd4);
        cmd(OP_SWAP, 16'd0);
        check_stack("swap", 16'd3, 16'd4, 5'd2);
        cmd(OP_OVER, 16'd0);
        check_stack("over", 16'd4, 16'd3, 5'd3);
        cmd(OP_DROP, 16'd0);
        check_stack("drop", 16'd3, 16'd4, 5'd2);
        cmd(OP_UNA, 16'd9);
        check_stack("una", 16'd9, 16'd4, 5'd2);
        cmd(OP_DUP, 16'd0);
        check_stack("dup", 16'd9, 16'd9, 5'd3);
        cmd(OP_DROP, 16'd0);
        check_stack("dup_drop", 16'd9, 16'd4, 5'd2);
        drive(OP_PUSH, 16'd77, 16'd0, 1'b0, 1'b0);
        check_stack("invalid_push", 16'd9, 16'd4, 5'd2);
        cmd(OP_NOP, 16'd0);
        check_stack("nop", 16'd9, 16'd4, 5'd2);

        // fill to capacity, then overflow
        apply_reset();
        for (int i = 1; i <= 18; i++) push(16'(i));
        check_stack("fill", 16'd18, 16'd17, 5'd18);
        check_eq("fill.full", full, 1'b1);
        check_eq("fill.ovf", ovf, 1'b0);
        push(16'd99);
        check_stack("ovf_push", 16'd18, 16'd17, 5'd18);
        check_eq("ovf_push.ovf", ovf, 1'b1);
        check_eq("ovf_push.full", full, 1'b1);
        drive(OP_NOP, 16'd0, 16'd0, 1'b1, 1'b1);
        check_eq("ovf_clr", ovf, 1'b0);
        cmd(OP_OVER, 16'd0);
        check_stack("ovf_over", 16'd18, 16'd17, 5'd18);
        check_eq("ovf_over.ovf", ovf, 1'b1);
        drive(OP_NOP, 16'd0, 16'd0, 1'b0, 1'b1);
        check_eq("ovf_clr2", ovf, 1'b0);

        // drain: T walks 17..1 then 0
        for (int k = 1; k <= 18; k++) exp_q.push_back(16'(18 - k));
        for (int k = 1; k <= 18; k++) begin
            logic [15:0] t_e;
            logic [15:0] y_e;
            cmd(OP_DROP, 16'd0);
            t_e = exp_q.pop_front();
            y_e = (k < 17) ? 16'(17 - k) : 16'd0;
            check_stack($sformatf("drain%0d", k), t_e, y_e, 5'(18 - k));
        end
        check_eq("drain.empty", empty, 1'b1);
        check_eq("drain.unf", unf, 1'b0);
        cmd(OP_DROP, 16'd0);
        check_eq("unf_drop.unf", unf, 1'b1);
        check_eq("unf_drop.depth", depth, 5'd0);

        // set wins over err_clr; err_clr alone clears
        drive(OP_BIN, 16'd0, 16'd5, 1'b1, 1'b1);
        check_eq("clr_vs_set.unf", unf, 1'b1);
        check_stack("clr_vs_set", 16'd0, 16'd0, 5'd0);
        drive(OP_NOP, 16'd0, 16'd0, 1'b0, 1'b1);
        check_eq("clr_alone.unf", unf, 1'b0);

        // minimum-depth violations at depth 1
        push(16'd6);
        cmd(OP_BIN, 16'd50);
        check_stack("bin_d1", 16'd6, 16'd0, 5'd1);
        check_eq("bin_d1.unf", unf, 1'b1);
        drive(OP_NOP, 16'd0, 16'd0, 1'b0, 1'b1);
        cmd(OP_SWAP, 16'd0);
        check_eq("swap_d1.unf", unf, 1'b1);
        check_stack("swap_d1", 16'd6, 16'd0, 5'd1);
        cmd(OP_UNA, 16'd11);
        check_stack("una_d1", 16'd11, 16'd0, 5'd1);

        // asynchronous reset between edges at depth 5, then immediate reuse
        apply_reset();
        for (int i = 1; i <= 5; i++) push(16'(i * 10));
        check_stack("pre_async", 16'd50, 16'd40, 5'd5);
        #2 rst_n = 1'b0;
        #1;
        check_stack("async_rst", 16'd0, 16'd0, 5'd0);
        rst_n = 1'b1;
        push(16'd42);
        check_stack("post_rst", 16'd42, 16'd0, 5'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
